// File: rtl/rca_word_sequencer.sv
// rtl/rca_word_sequencer.sv - multi-word carry sequencer feeding a shared ripple-carry adder
//
// Accepts operand word pairs (least-significant word first) on a valid/ready
// stream, presents them to an external combinational adder from a holding
// register, chains carry-out into the next word's carry-in, and registers each
// sum word onto a valid/ready output stream.
//
// Optional feature: define RCA_SEQ_SUB_EN to add the in_sub port, which turns
// a packet into a - b (b inverted, carry-in 1 on the first word).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               operand stream handshake
//   in_a, in_b, in_last             operand words, most-significant-word flag
//   in_sub                          subtract packet (RCA_SEQ_SUB_EN only)
//   add_a, add_b, add_cin           adder operands and carry-in
//   add_sum, add_cout               adder results (combinational return)
//   out_valid/out_ready             result stream handshake
//   out_sum, out_last, out_cout     result word, last flag, final carry-out
//   out_idx                         word index within the packet
module rca_word_sequencer #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
`ifdef RCA_SEQ_SUB_EN
    input  logic             in_sub,
`endif
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_last,
    output logic             out_cout,
    output logic [IDXW-1:0]  out_idx
);

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_MID   = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic              hold_full;
    logic [WIDTH-1:0]  hold_a;
    logic [WIDTH-1:0]  hold_b;
    logic              hold_last;
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;
    logic              sub_q;

    logic              take;
    logic              accept;

    assign take     = hold_full && (!out_valid || out_ready);
    assign in_ready = !hold_full || take;
    assign accept   = in_valid && in_ready;

    // Holding register: reloads on accept even when the old word is being
    // taken in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_a    <= '0;
            hold_b    <= '0;
            hold_last <= 1'b0;
        end else begin
            if (accept) begin
                hold_full <= 1'b1;
                hold_a    <= in_a;
                hold_b    <= in_b;
                hold_last <= in_last;
            end else if (take) begin
                hold_full <= 1'b0;
            end
        end
    end

`ifdef RCA_SEQ_SUB_EN
    // in_first_q tracks packet boundaries on the input side, which can run one
    // word ahead of the FSM (which follows the held word). Mid-packet words
    // inherit the mode of the word accepted before them.
    logic in_first_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_first_q <= 1'b1;
            sub_q      <= 1'b0;
        end else if (accept) begin
            in_first_q <= in_last;
            if (in_first_q) begin
                sub_q <= in_sub;
            end
        end
    end
`else
    assign sub_q = 1'b0;
`endif

    assign add_a   = hold_a;
    assign add_b   = sub_q ? ~hold_b : hold_b;
    assign add_cin = (state_q == ST_FIRST) ? sub_q : carry_q;

    // Result register, carry chain and word index all advance on take.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_idx   <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
        end else begin
            if (take) begin
                out_valid <= 1'b1;
                out_sum   <= add_sum;
                out_last  <= hold_last;
                out_cout  <= hold_last ? add_cout : 1'b0;
                out_idx   <= idx_q;
                carry_q   <= hold_last ? 1'b0 : add_cout;
                // Wraps modulo 2^IDXW; the carry chain is unaffected.
                idx_q     <= hold_last ? '0 : idx_q + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (take) begin
            state_d = hold_last ? ST_FIRST : ST_MID;
        end
    end

endmodule

// File: tb/tb_rca_word_sequencer.sv
// tb/tb_rca_word_sequencer.sv - self-checking bench for rca_word_sequencer
module tb_rca_word_sequencer;

    localparam int W  = 32;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_last = 1'b0;
    logic          in_sub = 1'b0;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_cin;
    logic [W-1:0]  add_sum;
    logic          add_cout;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_sum;
    logic          out_last;
    logic          out_cout;
    logic [IW-1:0] out_idx;

    always #5 clk = ~clk;

    // Downstream combinational adder.
    assign {add_cout, add_sum} = (W+1)'(add_a) + (W+1)'(add_b) + (W+1)'(add_cin);

    rca_word_sequencer #(.WIDTH(W), .IDXW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
`ifdef RCA_SEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_idx   (out_idx)
    );

    typedef struct packed {
        logic [W-1:0]  sum;
        logic          last;
        logic          cout;
        logic [IW-1:0] idx;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         last;
        res_t         exp;
    } vec_t;

    res_t exp_q[$];
    res_t tq[$];
    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;

    // Reference model state: a packet is a long addition done word by word.
    logic          m_first = 1'b1;
    logic          m_carry = 1'b0;
    logic          m_sub   = 1'b0;
    logic [IW-1:0] m_idx   = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic last, input logic sub);
        logic         s;
        logic [W-1:0] beff;
        logic [W:0]   t;
        res_t         r;
        s    = m_first ? sub : m_sub;
        beff = s ? ~b : b;
        t    = (W+1)'(a) + (W+1)'(beff) + (W+1)'(m_first ? s : m_carry);
        r.sum  = t[W-1:0];
        r.last = last;
        r.cout = last ? t[W] : 1'b0;
        r.idx  = m_idx;
        exp_q.push_back(r);
        m_sub   = s;
        m_carry = last ? 1'b0 : t[W];
        m_idx   = last ? '0 : m_idx + 1'b1;
        m_first = last;
    endtask

    task automatic monitor();
        logic stall_prev;
        res_t snap;
        res_t got;
        res_t e;
        stall_prev = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                tq.delete();
                m_first = 1'b1;
                m_carry = 1'b0;
                m_sub   = 1'b0;
                m_idx   = '0;
                stall_prev = 1'b0;
            end else begin
                got.sum  = out_sum;
                got.last = out_last;
                got.cout = out_cout;
                got.idx  = out_idx;
                if (stall_prev) begin
                    chk("stall_stable", {out_valid, got}, {1'b1, snap});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 64'(got), 64'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        chk("model_result", 64'(got), 64'(e));
                    end
                    if (tq.size() != 0) begin
                        e = tq.pop_front();
                        chk("table_result", 64'(got), 64'(e));
                    end
                end
                stall_prev = out_valid && !out_ready;
                snap = got;
                if (in_valid && in_ready) begin
                    model_push(in_a, in_b, in_last, in_sub);
                end
            end
        end
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    endtask

    // Call at posedge+1/+2; returns at posedge+1 after the accepting edge.
    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic last, input logic sub);
        int cnt;
        in_a = a;
        in_b = b;
        in_last = last;
        in_sub = sub;
        in_valid = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!in_ready && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 1000) chk("accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (!out_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("out_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while ((exp_q.size() != 0 || tq.size() != 0) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk("drain", 64'(exp_q.size() + tq.size()), 64'd0);
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic l,
                                input logic [W-1:0] s, input logic el, input logic ec,
                                input logic [IW-1:0] ei);
        vec_t v;
        v.a = a;
        v.b = b;
        v.last = l;
        v.exp.sum = s;
        v.exp.last = el;
        v.exp.cout = ec;
        v.exp.idx = ei;
        return v;
    endfunction

    vec_t tbl[8];

    initial begin
        logic [W-1:0] snap_sum;
        fork
            monitor();
            ready_drv();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_fields", {out_sum, out_last, out_cout, out_idx}, 64'd0);
        chk("rst_add_cin", 64'(add_cin), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed table, sent back to back
        tbl[0] = mk(32'hFFFF_FFFF, 32'h1,         1'b1, 32'h0,         1'b1, 1'b1, 8'd0);
        tbl[1] = mk(32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0,         1'b0, 1'b0, 8'd0);
        tbl[2] = mk(32'h0,         32'h0,         1'b1, 32'h1,         1'b1, 1'b0, 8'd1);
        tbl[3] = mk(32'd5,         32'd7,         1'b1, 32'd12,        1'b1, 1'b0, 8'd0);
        tbl[4] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 8'd0);
        tbl[5] = mk(32'hFFFF_FFFF, 32'h0,         1'b1, 32'h0,         1'b1, 1'b1, 8'd1);
        tbl[6] = mk(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0,         1'b1, 1'b1, 8'd0);
        tbl[7] = mk(32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_6789, 1'b1, 1'b0, 8'd0);
        foreach (tbl[i]) tq.push_back(tbl[i].exp);
        for (int i = 0; i < 8; i++) send_word(tbl[i].a, tbl[i].b, tbl[i].last, 1'b0);
        drain();

        // Two-word chain stalled at the output: word 1 must see carry-in 1
        ready_mode = 1;
        @(posedge clk);
        #2;
        send_word(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        send_word(32'h0, 32'h0, 1'b1, 1'b0);
        chk("chain_add_cin", 64'(add_cin), 64'd1);
        chk("chain_in_ready", 64'(in_ready), 64'd0);
        chk("chain_word0", {out_valid, out_sum}, {31'd0, 1'b1, 32'h0});
        ready_mode = 0;
        drain();

        // Back-pressure on a 3-word packet for 5 cycles
        ready_mode = 1;
        @(posedge clk);
        #2;
        send_word(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send_word(32'h0, 32'h0, 1'b0, 1'b0);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        snap_sum = out_sum;
        in_a = 32'd1;
        in_b = 32'd2;
        in_last = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready_held", 64'(in_ready), 64'd0);
            chk("bp_out_sum_held", 64'(out_sum), 64'(snap_sum));
        end
        ready_mode = 0;
        @(posedge clk);
        #2;
        send_word(32'd1, 32'd2, 1'b1, 1'b0);
        drain();

        // Reset mid-packet: stale carry must be discarded
        @(posedge clk);
        #2;
        send_word(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_word(32'd5, 32'd7, 1'b1, 1'b0);
        chk("midrst_add_cin", 64'(add_cin), 64'd0);
        wait_out();
        chk("midrst_sum", {out_sum, out_last, out_cout}, {30'd0, 32'd12, 1'b1, 1'b0});
        drain();

        // Index wrap: 257-word packet of zeros
        @(posedge clk);
        #2;
        for (int i = 0; i < 257; i++) send_word(32'h0, 32'h0, (i == 256), 1'b0);
        drain();

`ifdef RCA_SEQ_SUB_EN
        // Subtract: 1 - 2 borrows
        @(posedge clk);
        #2;
        send_word(32'd1, 32'd2, 1'b1, 1'b1);
        wait_out();
        chk("sub_result", {out_sum, out_cout}, {31'd0, 32'hFFFF_FFFF, 1'b0});
        drain();
`endif

        // Randomized packets with random gaps and random back-pressure
        ready_mode = 2;
        @(posedge clk);
        #2;
        for (int p = 0; p < 40; p++) begin
            int  len;
            logic sub;
            len = $urandom_range(1, 5);
`ifdef RCA_SEQ_SUB_EN
            sub = 1'($urandom_range(0, 1));
`else
            sub = 1'b0;
`endif
            for (int w = 0; w < len; w++) begin
                logic [W-1:0] a;
                logic [W-1:0] b;
                a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
                b = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
                send_word(a, b, (w == len - 1), sub);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        ready_mode = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
